// File: rtl/blink_rate_detector_if.sv
// Signal bundle between the blink-rate detector and its environment:
// the measured square wave in, rate code / valid / strobe / one-hot LEDs out.
interface blink_rate_detector_if;
  logic       i_Signal;
  logic [2:0] o_Rate;
  logic       o_Valid;
  logic       o_Rate_Strobe;
  logic       o_LED_1;
  logic       o_LED_2;
  logic       o_LED_3;
  logic       o_LED_4;

  modport master (
    output i_Signal,
    input  o_Rate, o_Valid, o_Rate_Strobe, o_LED_1, o_LED_2, o_LED_3, o_LED_4
  );

  modport slave (
    input  i_Signal,
    output o_Rate, o_Valid, o_Rate_Strobe, o_LED_1, o_LED_2, o_LED_3, o_LED_4
  );
endinterface

// File: rtl/blink_rate_detector.sv
// Measures the period between rising edges of an asynchronous square wave and
// locks onto one of four blink rates after g_CONFIRM consecutive matching periods.
module blink_rate_detector #(
  parameter int unsigned g_PERIOD_1HZ  = 32'd25000000,
  parameter int unsigned g_PERIOD_2HZ  = 32'd12500000,
  parameter int unsigned g_PERIOD_5HZ  = 32'd5000000,
  parameter int unsigned g_PERIOD_10HZ = 32'd2500000,
  parameter int unsigned g_TOL_SHIFT   = 32'd4,
  parameter int unsigned g_CONFIRM     = 32'd2,
  parameter int unsigned g_TIMEOUT     = 32'd50000000
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst_L,
  blink_rate_detector_if.slave   bus
);

  localparam int unsigned MW = (g_CONFIRM < 32'd1) ? 32'd1 : $clog2(g_CONFIRM + 32'd1);
  localparam logic [MW-1:0] CONFIRM_C = MW'(g_CONFIRM);
  localparam logic [31:0]   TIMEOUT_C = 32'(g_TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

  // Widened to 33 bits so nominal + tolerance cannot wrap.
  function automatic logic in_window(input logic [32:0] p, input logic [31:0] n);
    logic [32:0] tol;
    tol = {1'b0, n >> g_TOL_SHIFT};
    return (p >= ({1'b0, n} - tol)) && (p <= ({1'b0, n} + tol));
  endfunction

  function automatic logic [2:0] classify(input logic [32:0] p);
    logic [2:0] c;
    c = 3'd0;
    if (in_window(p, g_PERIOD_1HZ))       c = 3'd1;
    else if (in_window(p, g_PERIOD_2HZ))  c = 3'd2;
    else if (in_window(p, g_PERIOD_5HZ))  c = 3'd3;
    else if (in_window(p, g_PERIOD_10HZ)) c = 3'd4;
    else                                  c = 3'd0;
    return c;
  endfunction

  // Returns {LED_1, LED_2, LED_3, LED_4}; LED_1 is the fastest rate.
  function automatic logic [3:0] led_decode(input logic [2:0] rate);
    logic [3:0] l;
    case (rate)
      3'd1:    l = 4'b0001;
      3'd2:    l = 4'b0010;
      3'd3:    l = 4'b0100;
      3'd4:    l = 4'b1000;
      default: l = 4'b0000;
    endcase
    return l;
  endfunction

  logic          sync1_r, sync2_r, sync3_r;
  logic          edge_s;
  state_t        state_r, state_nxt_s;
  logic [31:0]   cnt_r, cnt_nxt_s;
  logic [2:0]    cand_r, cand_nxt_s;
  logic [MW-1:0] match_r, match_nxt_s;
  logic [2:0]    rate_r, rate_nxt_s;
  logic          valid_r, valid_nxt_s;
  logic          strobe_r;
  logic [3:0]    led_r;
  logic [2:0]    class_s;
  logic          timeout_s;

  assign edge_s    = sync2_r & ~sync3_r;
  assign class_s   = classify({1'b0, cnt_r} + 33'd1);
  assign timeout_s = (cnt_r >= (TIMEOUT_C - 32'd1));

  // Synchronize the asynchronous input and keep one extra stage for edge detect.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      sync3_r <= 1'b0;
    end else begin
      sync1_r <= bus.i_Signal;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
    end
  end

  // Next-state, period counter and rate decisions.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    cand_nxt_s  = cand_r;
    match_nxt_s = match_r;
    rate_nxt_s  = rate_r;
    valid_nxt_s = valid_r;

    if ((state_r == ST_IDLE) || edge_s) begin
      cnt_nxt_s = 32'd0;
    end else if (cnt_r < TIMEOUT_C) begin
      cnt_nxt_s = cnt_r + 32'd1;
    end else begin
      cnt_nxt_s = cnt_r;
    end

    case (state_r)
      ST_IDLE: begin
        if (edge_s) begin
          state_nxt_s = ST_MEASURE;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_MEASURE: begin
        if (edge_s) begin
          if (class_s == 3'd0) begin
            cand_nxt_s  = 3'd0;
            match_nxt_s = '0;
          end else if (class_s == cand_r) begin
            match_nxt_s = match_r + MW'(1);
          end else begin
            cand_nxt_s  = class_s;
            match_nxt_s = MW'(1);
          end
          if ((class_s != 3'd0) && (match_nxt_s == CONFIRM_C)) begin
            rate_nxt_s  = cand_nxt_s;
            valid_nxt_s = 1'b1;
            state_nxt_s = ST_LOCKED;
          end else begin
            state_nxt_s = ST_MEASURE;
          end
        end else if (timeout_s) begin
          cand_nxt_s  = 3'd0;
          match_nxt_s = '0;
          rate_nxt_s  = 3'd0;
          valid_nxt_s = 1'b0;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_MEASURE;
        end
      end
      ST_LOCKED: begin
        if (edge_s) begin
          if (class_s != cand_r) begin
            rate_nxt_s  = 3'd0;
            valid_nxt_s = 1'b0;
            cand_nxt_s  = class_s;
            match_nxt_s = (class_s != 3'd0) ? MW'(1) : '0;
            state_nxt_s = ST_MEASURE;
          end else begin
            state_nxt_s = ST_LOCKED;
          end
        end else if (timeout_s) begin
          cand_nxt_s  = 3'd0;
          match_nxt_s = '0;
          rate_nxt_s  = 3'd0;
          valid_nxt_s = 1'b0;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_LOCKED;
        end
      end
      default: begin
        cand_nxt_s  = 3'd0;
        match_nxt_s = '0;
        rate_nxt_s  = 3'd0;
        valid_nxt_s = 1'b0;
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; LEDs and strobe are derived from the next rate.
  always_ff @(posedge i_Clk or negedge i_Rst_L) begin
    if (!i_Rst_L) begin
      state_r  <= ST_IDLE;
      cnt_r    <= 32'd0;
      cand_r   <= 3'd0;
      match_r  <= '0;
      rate_r   <= 3'd0;
      valid_r  <= 1'b0;
      strobe_r <= 1'b0;
      led_r    <= 4'b0000;
    end else begin
      state_r  <= state_nxt_s;
      cnt_r    <= cnt_nxt_s;
      cand_r   <= cand_nxt_s;
      match_r  <= match_nxt_s;
      rate_r   <= rate_nxt_s;
      valid_r  <= valid_nxt_s;
      strobe_r <= (rate_nxt_s != rate_r);
      led_r    <= led_decode(rate_nxt_s);
    end
  end

  assign bus.o_Rate        = rate_r;
  assign bus.o_Valid       = valid_r;
  assign bus.o_Rate_Strobe = strobe_r;
  assign bus.o_LED_1       = led_r[3];
  assign bus.o_LED_2       = led_r[2];
  assign bus.o_LED_3       = led_r[1];
  assign bus.o_LED_4       = led_r[0];

endmodule

// File: tb/tb_blink_rate_detector.sv
// Directed bench for blink_rate_detector with short periods (1000/500/200/100),
// tolerance shift 4, two-period confirm and a 2000-clock timeout.
module tb_blink_rate_detector;

  logic clk;
  logic rst_n;
  int   tests;
  int   fails;
  int   ph;
  int   strobes;
  int   seen_out;
  int   s0;

  blink_rate_detector_if bif ();

  blink_rate_detector #(
    .g_PERIOD_1HZ (32'd1000),
    .g_PERIOD_2HZ (32'd500),
    .g_PERIOD_5HZ (32'd200),
    .g_PERIOD_10HZ(32'd100),
    .g_TOL_SHIFT  (32'd4),
    .g_CONFIRM    (32'd2),
    .g_TIMEOUT    (32'd2000)
  ) dut (
    .i_Clk  (clk),
    .i_Rst_L(rst_n),
    .bus    (bif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] leds();
    return 32'({bif.o_LED_1, bif.o_LED_2, bif.o_LED_3, bif.o_LED_4});
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    if (bif.o_Rate_Strobe) strobes++;
    if ((bif.o_Rate != 3'd0) || bif.o_Valid || bif.o_Rate_Strobe || (leds() != 32'd0)) seen_out++;
  endtask

  task automatic drive(input int period, input int n);
    for (int i = 0; i < n; i++) begin
      bif.i_Signal = (ph < period / 2);
      step();
      ph = (ph + 1 >= period) ? 0 : ph + 1;
    end
  endtask

  task automatic hold_low(input int n);
    bif.i_Signal = 1'b0;
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    bif.i_Signal = 1'b0;
    ph           = 0;
    repeat (3) @(posedge clk);
    #1;
    rst_n   = 1'b1;
    strobes = 0;
  endtask

  initial begin
    tests = 0; fails = 0; ph = 0; strobes = 0; seen_out = 0;
    rst_n = 1'b0;
    bif.i_Signal = 1'b0;

    // 1: reset state and a quiet input
    #3;
    check("rst_rate",   32'(bif.o_Rate), 32'd0);
    check("rst_valid",  32'(bif.o_Valid), 32'd0);
    check("rst_strobe", 32'(bif.o_Rate_Strobe), 32'd0);
    check("rst_led",    leds(), 32'd0);
    do_reset();
    seen_out = 0;
    hold_low(3000);
    check("quiet_seen",    32'(seen_out), 32'd0);
    check("quiet_strobes", 32'(strobes), 32'd0);

    // 2: period 200 locks at 5 Hz on the 3rd edge + 2 clocks
    do_reset();
    drive(200, 402);
    check("p200_prelock_rate", 32'(bif.o_Rate), 32'd0);
    check("p200_prelock_strb", 32'(strobes), 32'd0);
    drive(200, 1);
    check("p200_rate",   32'(bif.o_Rate), 32'd3);
    check("p200_valid",  32'(bif.o_Valid), 32'd1);
    check("p200_led",    leds(), 32'h4);
    check("p200_strobe", 32'(bif.o_Rate_Strobe), 32'd1);
    drive(200, 1);
    check("p200_strobe_off", 32'(bif.o_Rate_Strobe), 32'd0);
    s0 = strobes;
    drive(200, 600);
    check("p200_no_more_strobes", 32'(strobes), 32'(s0));
    check("p200_hold_rate",       32'(bif.o_Rate), 32'd3);

    // 3: tolerance boundaries
    do_reset();
    drive(188, 2 * 188 + 3);
    check("p188_rate", 32'(bif.o_Rate), 32'd3);
    do_reset();
    drive(212, 2 * 212 + 3);
    check("p212_rate", 32'(bif.o_Rate), 32'd3);
    do_reset();
    drive(213, 213 * 6);
    check("p213_rate",    32'(bif.o_Rate), 32'd0);
    check("p213_strobes", 32'(strobes), 32'd0);

    // 4: 10 Hz lock, then switch to 1 Hz
    do_reset();
    drive(100, 203);
    check("p100_rate", 32'(bif.o_Rate), 32'd4);
    check("p100_led",  leds(), 32'h8);
    drive(100, 97);
    ph = 0;
    drive(1000, 1003);
    check("sw_unlock_rate",   32'(bif.o_Rate), 32'd0);
    check("sw_unlock_valid",  32'(bif.o_Valid), 32'd0);
    check("sw_unlock_strobe", 32'(bif.o_Rate_Strobe), 32'd1);
    drive(1000, 1000);
    check("sw_lock_rate",   32'(bif.o_Rate), 32'd1);
    check("sw_lock_led",    leds(), 32'h1);
    check("sw_lock_strobe", 32'(bif.o_Rate_Strobe), 32'd1);

    // 5: 2 Hz lock, then timeout and relock
    do_reset();
    drive(500, 1003);
    check("p500_rate", 32'(bif.o_Rate), 32'd2);
    check("p500_led",  leds(), 32'h2);
    drive(500, 497);
    s0 = strobes;
    hold_low(1502);
    check("to_before_rate",    32'(bif.o_Rate), 32'd2);
    check("to_before_strobes", 32'(strobes), 32'(s0));
    hold_low(1);
    check("to_rate",   32'(bif.o_Rate), 32'd0);
    check("to_valid",  32'(bif.o_Valid), 32'd0);
    check("to_strobe", 32'(bif.o_Rate_Strobe), 32'd1);
    check("to_led",    leds(), 32'd0);
    ph = 0;
    drive(500, 1002);
    check("relock_early_rate", 32'(bif.o_Rate), 32'd0);
    drive(500, 1);
    check("relock_rate", 32'(bif.o_Rate), 32'd2);

    // 6: asynchronous reset while locked
    do_reset();
    drive(100, 203);
    check("ar_pre_rate", 32'(bif.o_Rate), 32'd4);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_rate",   32'(bif.o_Rate), 32'd0);
    check("ar_valid",  32'(bif.o_Valid), 32'd0);
    check("ar_strobe", 32'(bif.o_Rate_Strobe), 32'd0);
    check("ar_led",    leds(), 32'd0);
    bif.i_Signal = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    ph = 0;
    drive(100, 202);
    check("ar_relock_early", 32'(bif.o_Rate), 32'd0);
    drive(100, 1);
    check("ar_relock_rate",  32'(bif.o_Rate), 32'd4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
